led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 139 +++++++++++++
 tb/tb_led_pattern_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: programmable-rate tick generator driving a 4-mode LED pattern engine routed to RGB banks.
// Latency: o_tick is registered, o_led steps on the edge after o_tick is high, and the colour banks follow o_led combinationally.
// Backpressure: none. i_en=0 freezes the counter and the pattern. Optional PWM dimming is enabled with LED_PATTERN_PWM_DIM_EN.
module led_pattern_gen #(
  parameter int N_LED    = 4,
  parameter int CNT_W    = 32,
  parameter int LIMIT0   = 50000000,
  parameter int LIMIT1   = 25000000,
  parameter int LIMIT2   = 12500000,
  parameter int LIMIT3   = 6250000,
  parameter int PWM_W    = 4,
  parameter int DIM_DUTY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_rate,
  input  logic [1:0]       i_mode,
  input  logic [1:0]       i_color,
  output logic             o_tick,
  output logic [N_LED-1:0] o_led,
  output logic [N_LED-1:0] o_led_r,
  output logic [N_LED-1:0] o_led_g,
  output logic [N_LED-1:0] o_led_b
);

  localparam logic [CNT_W-1:0] P_LIM0 = CNT_W'(LIMIT0);
  localparam logic [CNT_W-1:0] P_LIM1 = CNT_W'(LIMIT1);
  localparam logic [CNT_W-1:0] P_LIM2 = CNT_W'(LIMIT2);
  localparam logic [CNT_W-1:0] P_LIM3 = CNT_W'(LIMIT3);
  localparam logic [N_LED-1:0] P_ONE  = {{(N_LED-1){1'b0}}, 1'b1};

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic [N_LED-1:0] r_pattern;
  dir_t             r_dir;
  logic [1:0]       r_mode_q;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_limit_m1;
  logic             w_dim;
  logic             w_sel_r;
  logic             w_sel_g;
  logic             w_sel_b;

  // Pick the tick period for the requested rate
  always_comb begin
    w_limit = P_LIM0;
    case (i_rate)
      2'd0:    w_limit = P_LIM0;
      2'd1:    w_limit = P_LIM1;
      2'd2:    w_limit = P_LIM2;
      default: w_limit = P_LIM3;
    endcase
  end

  assign w_limit_m1 = w_limit - CNT_W'(1);

  // Tick counter. The >= compare makes a drop to a faster rate fire once and then restart from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (r_cnt >= w_limit_m1) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // Pattern engine. A mode change only reloads the pattern; movement resumes on the following tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= P_ONE;
      r_dir     <= DIR_LEFT;
      r_mode_q  <= 2'b00;
    end else if (r_tick) begin
      if (i_mode != r_mode_q) begin
        r_pattern <= P_ONE;
        r_dir     <= DIR_LEFT;
        r_mode_q  <= i_mode;
      end else begin
        case (r_mode_q)
          2'b00: r_pattern <= {r_pattern[N_LED-2:0], r_pattern[N_LED-1]};
          2'b01: r_pattern <= {r_pattern[0], r_pattern[N_LED-1:1]};
          2'b10: begin
            // Reverse on reaching an end LED so that the end LED is lit for only one step
            if (r_dir == DIR_LEFT && r_pattern[N_LED-1]) begin
              r_dir     <= DIR_RIGHT;
              r_pattern <= r_pattern >> 1;
            end else if (r_dir == DIR_RIGHT && r_pattern[0]) begin
              r_dir     <= DIR_LEFT;
              r_pattern <= r_pattern << 1;
            end else if (r_dir == DIR_LEFT) begin
              r_pattern <= r_pattern << 1;
            end else begin
              r_pattern <= r_pattern >> 1;
            end
          end
          default: r_pattern <= ~r_pattern;
        endcase
      end
    end
  end

`ifdef LED_PATTERN_PWM_DIM_EN
  logic [PWM_W-1:0] r_pwm_cnt;

  // Free-running dimming counter that gates the colour banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
  end

  assign w_dim = (32'(r_pwm_cnt) < DIM_DUTY);
`else
  logic w_unused_pwm_cfg;
  assign w_unused_pwm_cfg = PWM_W[0] ^ DIM_DUTY[0];
  assign w_dim = 1'b1;
`endif

  assign w_sel_r = (i_color == 2'b00) || (i_color == 2'b11);
  assign w_sel_g = (i_color == 2'b01) || (i_color == 2'b11);
  assign w_sel_b = (i_color == 2'b10) || (i_color == 2'b11);

  assign o_tick  = r_tick;
  assign o_led   = r_pattern;
  assign o_led_r = r_pattern & {N_LED{w_sel_r & w_dim}};
  assign o_led_g = r_pattern & {N_LED{w_sel_g & w_dim}};
  assign o_led_b = r_pattern & {N_LED{w_sel_b & w_dim}};

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen using small limits 4/8/16/32 and N_LED=4.
// Pattern sequences are table-driven and checked through a scoreboard queue, one entry per tick.
// Multi-cycle cases are hand-written: rate switching, freeze, colour routing and reset mid-period.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic [1:0] i_rate;
  logic [1:0] i_mode;
  logic [1:0] i_color;
  logic       o_tick;
  logic [3:0] o_led, o_led_r, o_led_g, o_led_b;

  int n_cmp = 0;
  int n_bad = 0;

  led_pattern_gen #(
    .N_LED(4), .CNT_W(32), .LIMIT0(4), .LIMIT1(8), .LIMIT2(16), .LIMIT3(32),
    .PWM_W(4), .DIM_DUTY(4)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_rate(i_rate), .i_mode(i_mode),
    .i_color(i_color), .o_tick(o_tick), .o_led(o_led), .o_led_r(o_led_r),
    .o_led_g(o_led_g), .o_led_b(o_led_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  n;
    logic [31:0] seq;   // expected o_led after each tick, nibble 0 first
  } seq_vec_t;

  typedef struct packed {
    logic [1:0] color;
    logic       r, g, b;
  } col_vec_t;

  seq_vec_t   stab[4];
  col_vec_t   ctab[4];
  logic [3:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step edges until o_tick is sampled high; returns -1 when the budget expires
  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!o_tick && cyc < budget);
    if (!o_tick) cyc = -1;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    rst = 1'b1; i_en = 1'b1; i_rate = 2'd0; i_mode = mode;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_seq(input seq_vec_t v);
    int         cyc;
    logic [3:0] exp;
    do_reset(v.mode);
    for (int i = 0; i < int'(v.n); i++) sb_q.push_back(v.seq[4*i +: 4]);
    for (int i = 0; sb_q.size() > 0; i++) begin
      wait_tick(100, cyc);
      check($sformatf("seq_m%0d_gap%0d", v.mode, i), cyc, (i == 0) ? 4 : 3);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      check($sformatf("seq_m%0d_step%0d", v.mode, i), {28'd0, o_led}, {28'd0, exp});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   bad;
    logic [3:0] exp_pat;

    stab[0] = '{mode: 2'b00, n: 4'd4, seq: 32'h0000_1842};
    stab[1] = '{mode: 2'b01, n: 4'd5, seq: 32'h0001_2481};
    stab[2] = '{mode: 2'b10, n: 4'd8, seq: 32'h2124_8421};
    stab[3] = '{mode: 2'b11, n: 4'd4, seq: 32'h0000_E1E1};
    ctab[0] = '{color: 2'b00, r: 1'b1, g: 1'b0, b: 1'b0};
    ctab[1] = '{color: 2'b01, r: 1'b0, g: 1'b1, b: 1'b0};
    ctab[2] = '{color: 2'b10, r: 1'b0, g: 1'b0, b: 1'b1};
    ctab[3] = '{color: 2'b11, r: 1'b1, g: 1'b1, b: 1'b1};

    // Reset state
    rst = 1'b1; i_en = 1'b0; i_rate = 2'd0; i_mode = 2'b00; i_color = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led",  {28'd0, o_led},   32'h1);
    check("rst_tick", {31'd0, o_tick},  32'h0);
    check("rst_red",  {28'd0, o_led_r}, 32'h1);
    check("rst_grn",  {28'd0, o_led_g}, 32'h0);

    // Rate: period 4, then 8 after switching, then a drop to a faster rate fires at once
    do_reset(2'b00);
    wait_tick(100, cyc); check("rate0_first", cyc, 4);
    wait_tick(100, cyc); check("rate0_period", cyc, 4);
    i_rate = 2'd1;
    wait_tick(100, cyc); check("rate1_first", cyc, 8);
    wait_tick(100, cyc); check("rate1_period", cyc, 8);
    i_rate = 2'd3;
    repeat (11) @(posedge clk);
    #1;
    i_rate = 2'd0;
    wait_tick(100, cyc); check("rate_drop_immediate", cyc, 1);
    wait_tick(100, cyc); check("rate_drop_resume", cyc, 4);

    // Pattern sequences for all four modes
    for (int k = 0; k < 4; k++) run_seq(stab[k]);

    // Freeze: flash run left the pattern at 1110 with the counter at 1
    i_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_led !== 4'hE || o_tick !== 1'b0) bad++;
    end
    check("freeze_hold_cycles_bad", bad, 0);
    i_en = 1'b1;
    wait_tick(100, cyc); check("freeze_resume_gap", cyc, 3);
    @(posedge clk); #1;
    check("freeze_resume_led", {28'd0, o_led}, 32'h1);
    exp_pat = 4'b0001;
    i_en = 1'b0;

`ifdef LED_PATTERN_PWM_DIM_EN
    // Dimming: green bank active 4 cycles out of every 16
    i_color = 2'b01;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (o_led_g == exp_pat) bad++;
    end
    check("pwm_on_cycles", bad, 4);
`else
    // Colour routing changes without any clock edge
    for (int k = 0; k < 4; k++) begin
      i_color = ctab[k].color;
      #1;
      check($sformatf("col%0d_r", k), {28'd0, o_led_r}, {28'd0, ctab[k].r ? exp_pat : 4'd0});
      check($sformatf("col%0d_g", k), {28'd0, o_led_g}, {28'd0, ctab[k].g ? exp_pat : 4'd0});
      check($sformatf("col%0d_b", k), {28'd0, o_led_b}, {28'd0, ctab[k].b ? exp_pat : 4'd0});
    end
`endif

    // Reset mid-period forces reset values without a clock edge
    i_en = 1'b1;
    wait_tick(100, cyc); check("pre_rst_gap", cyc, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_led", {28'd0, o_led}, 32'hE);
    rst = 1'b1;
    #1;
    check("mid_rst_led",  {28'd0, o_led}, 32'h1);
    check("mid_rst_tick", {31'd0, o_tick}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_tick(100, cyc); check("post_rst_first", cyc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
